pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard and pipeline-control unit for the 5-stage MIPS CPU.
- Computes operand-forwarding selects and stage reset/enable signals.
- Adds behaviour the current controller lacks: configurable multi-cycle load-use bubbles, data-memory wait freeze, taken-branch flush of IF/ID, debug single-step edge detection, and saturating stall/flush performance counters.
- Sits beside the instruction decoder; consumes decoded register usage plus EXE/MEM feedback.

---
 rtl/pipe_hazard_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard detection and pipeline control for the 5-stage MIPS core.
//   Produces operand-forwarding selects for the ID-stage instruction and
//   per-stage reset/enable controls. It handles the following cases:
//     - load-use hazards, stalling for LUSE_BUBBLES cycles
//     - data-memory wait (freezes the whole pipe)
//     - taken-branch flush of IF/ID
//     - debug suspend with single-step on a rising edge of debug_step
//   It also keeps saturating stall/flush performance counters.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   addr_rs/addr_rt         source registers of the ID instruction
//   rs_used/rt_used         ID instruction actually reads that source
//   branch_taken            ID branch/jump resolved taken
//   regw_addr_exe, wb_wen_exe, is_load_exe   EXE destination info
//   regw_addr_mem, wb_wen_mem, is_load_mem   MEM destination info
//   dmem_req, dmem_ack      MEM-stage data-memory handshake
//   debug_en, debug_step    debug suspend and step request (level)
//   fwd_a, fwd_b            0 regfile, 1 EXE ALU, 2 MEM ALU, 3 MEM load data
//   <stage>_rst/<stage>_en  per-stage pipeline register controls
//   stall_cnt, flush_cnt    saturating performance counters
module pipe_hazard_ctrl #(
  parameter int ADDR_W       = 5,
  parameter int LUSE_BUBBLES = 1,
  parameter int CNT_W        = 16,
  parameter int DEBUG_EN     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_rs,
  input  logic [ADDR_W-1:0] addr_rt,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] regw_addr_exe,
  input  logic              wb_wen_exe,
  input  logic              is_load_exe,
  input  logic [ADDR_W-1:0] regw_addr_mem,
  input  logic              wb_wen_mem,
  input  logic              is_load_mem,
  input  logic              dmem_req,
  input  logic              dmem_ack,
  input  logic              debug_en,
  input  logic              debug_step,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              if_rst,
  output logic              if_en,
  output logic              id_rst,
  output logic              id_en,
  output logic              exe_rst,
  output logic              exe_en,
  output logic              mem_rst,
  output logic              mem_en,
  output logic              wb_rst,
  output logic              wb_en,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic {IDLE = 1'b0, BUBBLE = 1'b1} state_t;

  // Remaining bubbles loaded when entering BUBBLE (first bubble is the IDLE cycle).
  localparam logic [1:0]       BUB_INIT = 2'(LUSE_BUBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit               MULTI    = (LUSE_BUBBLES > 1);

  state_t           state_q, state_d;
  logic [1:0]       bub_q, bub_d;
  logic             step_prev_q, step_prev_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       haz_a, haz_b, hazard;
  logic [1:0] sel_a, sel_b;
  logic       hold, mem_wait, freeze, stall, flush;

  // ---------------------------------------------------------------------
  // Forwarding. A load still in EXE cannot be forwarded yet: it raises a
  // hazard and the select stays at the regfile (the cycle is stalled).
  // ---------------------------------------------------------------------
  always_comb begin
    haz_a = 1'b0;
    sel_a = 2'd0;
    if (rs_used && (addr_rs != '0)) begin
      if (wb_wen_exe && (regw_addr_exe == addr_rs)) begin
        if (is_load_exe) haz_a = 1'b1;
        else             sel_a = 2'd1;
      end else if (wb_wen_mem && (regw_addr_mem == addr_rs)) begin
        sel_a = is_load_mem ? 2'd3 : 2'd2;
      end
    end
  end

  always_comb begin
    haz_b = 1'b0;
    sel_b = 2'd0;
    if (rt_used && (addr_rt != '0)) begin
      if (wb_wen_exe && (regw_addr_exe == addr_rt)) begin
        if (is_load_exe) haz_b = 1'b1;
        else             sel_b = 2'd1;
      end else if (wb_wen_mem && (regw_addr_mem == addr_rt)) begin
        sel_b = is_load_mem ? 2'd3 : 2'd2;
      end
    end
  end

  assign hazard = haz_a | haz_b;

  // ---------------------------------------------------------------------
  // Debug hold: only a rising edge of debug_step lets one cycle through.
  // ---------------------------------------------------------------------
  generate
    if (DEBUG_EN != 0) begin : g_dbg
      assign hold        = debug_en & ~(debug_step & ~step_prev_q);
      assign step_prev_d = debug_step;
    end else begin : g_no_dbg
      assign hold        = 1'b0;
      assign step_prev_d = 1'b0;
    end
  endgenerate

  assign mem_wait = dmem_req & ~dmem_ack;
  assign freeze   = hold | mem_wait;
  assign stall    = (state_q == BUBBLE) | hazard;
  // Branches seen during a stall are dropped; ID re-presents them afterwards.
  assign flush    = branch_taken & ~stall;

  // ---------------------------------------------------------------------
  // Load-use FSM and counters. Nothing advances while frozen.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    bub_d       = bub_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!freeze) begin
      case (state_q)
        IDLE: begin
          if (hazard && MULTI) begin
            state_d = BUBBLE;
            bub_d   = BUB_INIT;
          end
        end
        BUBBLE: begin
          bub_d = bub_q - 2'd1;
          if (bub_q <= 2'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (stall && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bub_q       <= 2'd0;
      step_prev_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bub_q       <= bub_d;
      step_prev_q <= step_prev_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage controls, highest priority first.
  // ---------------------------------------------------------------------
  always_comb begin
    fwd_a   = sel_a;
    fwd_b   = sel_b;
    if_rst  = 1'b0;  if_en  = 1'b1;
    id_rst  = 1'b0;  id_en  = 1'b1;
    exe_rst = 1'b0;  exe_en = 1'b1;
    mem_rst = 1'b0;  mem_en = 1'b1;
    wb_rst  = 1'b0;  wb_en  = 1'b1;
    if (!rst_n) begin
      fwd_a   = 2'd0;
      fwd_b   = 2'd0;
      if_rst  = 1'b1;
      id_rst  = 1'b1;
      exe_rst = 1'b1;
      mem_rst = 1'b1;
      wb_rst  = 1'b1;
    end else if (freeze) begin
      if_en  = 1'b0;
      id_en  = 1'b0;
      exe_en = 1'b0;
      mem_en = 1'b0;
      wb_en  = 1'b0;
    end else if (stall) begin
      // Hold IF/ID and inject a bubble into EXE.
      if_en   = 1'b0;
      id_en   = 1'b0;
      exe_rst = 1'b1;
    end else if (flush) begin
      id_rst = 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (LUSE_BUBBLES=2, CNT_W=2).
// Each scenario task builds a stimulus list with expected outputs; the
// expectation is pushed to a scoreboard when its stimulus is driven and
// popped and compared once the combinational outputs have settled.
module tb_pipe_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 2;

  // Control vector order: if_rst,if_en,id_rst,id_en,exe_rst,exe_en,mem_rst,mem_en,wb_rst,wb_en
  localparam logic [9:0] C_RESET  = 10'b11_11_11_11_11;
  localparam logic [9:0] C_NORMAL = 10'b01_01_01_01_01;
  localparam logic [9:0] C_FREEZE = 10'b00_00_00_00_00;
  localparam logic [9:0] C_STALL  = 10'b00_00_11_01_01;
  localparam logic [9:0] C_FLUSH  = 10'b01_11_01_01_01;

  typedef struct packed {
    logic          rst_n;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          rs_u;
    logic          rt_u;
    logic          br;
    logic [AW-1:0] exe_a;
    logic          exe_w;
    logic          exe_l;
    logic [AW-1:0] mem_a;
    logic          mem_w;
    logic          mem_l;
    logic          dreq;
    logic          dack;
    logic          den;
    logic          dstep;
  } in_t;

  typedef struct packed {
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic [9:0]    ctl;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] addr_rs, addr_rt, regw_addr_exe, regw_addr_mem;
  logic          rs_used, rt_used, branch_taken, wb_wen_exe, is_load_exe;
  logic          wb_wen_mem, is_load_mem, dmem_req, dmem_ack, debug_en, debug_step;
  logic [1:0]    fwd_a, fwd_b;
  logic          if_rst, if_en, id_rst, id_en, exe_rst, exe_en;
  logic          mem_rst, mem_en, wb_rst, wb_en;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(
    .ADDR_W(AW), .LUSE_BUBBLES(2), .CNT_W(CW), .DEBUG_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .addr_rs(addr_rs), .addr_rt(addr_rt), .rs_used(rs_used), .rt_used(rt_used),
    .branch_taken(branch_taken),
    .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe), .is_load_exe(is_load_exe),
    .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem), .is_load_mem(is_load_mem),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .debug_en(debug_en), .debug_step(debug_step),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .if_rst(if_rst), .if_en(if_en), .id_rst(id_rst), .id_en(id_en),
    .exe_rst(exe_rst), .exe_en(exe_en), .mem_rst(mem_rst), .mem_en(mem_en),
    .wb_rst(wb_rst), .wb_en(wb_en),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  obs_t got;
  assign got = {fwd_a, fwd_b, if_rst, if_en, id_rst, id_en, exe_rst, exe_en,
                mem_rst, mem_en, wb_rst, wb_en, stall_cnt, flush_cnt};

  int   n_cmp = 0;
  int   n_err = 0;
  obs_t sb[$];
  in_t  stim_q[$];
  obs_t want_q[$];

  function automatic in_t idle();
    in_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  // lw r5 in EXE, ID reads r5 through RS (or RT).
  function automatic in_t lu_exe(input bit on_rt);
    in_t s;
    s = idle();
    if (on_rt) begin s.rt = 5'd5; s.rt_u = 1'b1; end
    else       begin s.rs = 5'd5; s.rs_u = 1'b1; end
    s.exe_a = 5'd5; s.exe_w = 1'b1; s.exe_l = 1'b1;
    return s;
  endfunction

  // Same load one stage later, now in MEM.
  function automatic in_t lu_mem(input bit on_rt);
    in_t s;
    s = idle();
    if (on_rt) begin s.rt = 5'd5; s.rt_u = 1'b1; end
    else       begin s.rs = 5'd5; s.rs_u = 1'b1; end
    s.mem_a = 5'd5; s.mem_w = 1'b1; s.mem_l = 1'b1;
    return s;
  endfunction

  function automatic obs_t ex(input logic [1:0] fa, input logic [1:0] fb,
                              input logic [9:0] ctl, input int sc, input int fc);
    obs_t o;
    o.fa = fa; o.fb = fb; o.ctl = ctl;
    o.sc = CW'(sc); o.fc = CW'(fc);
    return o;
  endfunction

  task automatic add(input in_t s, input obs_t e);
    stim_q.push_back(s);
    want_q.push_back(e);
  endtask

  task automatic apply(input in_t s);
    rst_n = s.rst_n; addr_rs = s.rs; addr_rt = s.rt; rs_used = s.rs_u; rt_used = s.rt_u;
    branch_taken = s.br;
    regw_addr_exe = s.exe_a; wb_wen_exe = s.exe_w; is_load_exe = s.exe_l;
    regw_addr_mem = s.mem_a; wb_wen_mem = s.mem_w; is_load_mem = s.mem_l;
    dmem_req = s.dreq; dmem_ack = s.dack; debug_en = s.den; debug_step = s.dstep;
  endtask

  task automatic do_reset();
    in_t s;
    s = idle();
    s.rst_n = 1'b0;
    apply(s);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    in_t s;
    obs_t e;
    s = lu_exe(1'b0); s.rst_n = 1'b0; s.br = 1'b1;
    add(s, ex(0, 0, C_RESET, 0, 0));
    s.dreq = 1'b1;
    add(s, ex(0, 0, C_RESET, 0, 0));
    add(idle(), ex(0, 0, C_NORMAL, 0, 0));
    add(idle(), ex(0, 0, C_NORMAL, 0, 0));
    foreach (stim_q[i]) begin
      apply(stim_q[i]); sb.push_back(want_q[i]);
      #2; e = sb.pop_front(); n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL reset[%0d]: got fa=%0d fb=%0d ctl=%b sc=%0d fc=%0d, want fa=%0d fb=%0d ctl=%b sc=%0d fc=%0d",
                 i, got.fa, got.fb, got.ctl, got.sc, got.fc, e.fa, e.fb, e.ctl, e.sc, e.fc);
      end else $display("reset[%0d] ok ctl=%b", i, got.ctl);
      @(posedge clk); #1;
    end
    stim_q.delete(); want_q.delete();
  endtask

  task automatic test_forwarding();
    in_t s;
    obs_t e;
    do_reset();
    s = idle(); s.rs = 3; s.rt = 3; s.rs_u = 1; s.rt_u = 1; s.exe_a = 3; s.exe_w = 1;
    add(s, ex(1, 1, C_NORMAL, 0, 0));
    s = idle(); s.rs = 3; s.rt = 3; s.rs_u = 1; s.rt_u = 1; s.mem_a = 3; s.mem_w = 1; s.mem_l = 1;
    add(s, ex(3, 3, C_NORMAL, 0, 0));
    s = idle(); s.rs = 3; s.rt = 7; s.rs_u = 1; s.rt_u = 1; s.exe_a = 3; s.exe_w = 1;
    s.mem_a = 7; s.mem_w = 1;
    add(s, ex(1, 2, C_NORMAL, 0, 0));
    s = idle(); s.rs = 3; s.rt = 3; s.rs_u = 1; s.rt_u = 1; s.exe_a = 3; s.exe_w = 1;
    s.mem_a = 3; s.mem_w = 1; s.mem_l = 1;
    add(s, ex(1, 1, C_NORMAL, 0, 0));
    s = idle(); s.rs_u = 1; s.rt_u = 1; s.exe_w = 1; s.mem_w = 1;
    add(s, ex(0, 0, C_NORMAL, 0, 0));
    s = idle(); s.rs = 3; s.rt = 3; s.rt_u = 1; s.exe_a = 3; s.exe_w = 1;
    add(s, ex(0, 1, C_NORMAL, 0, 0));
    s = idle(); s.rs = 3; s.rt = 3; s.rs_u = 1; s.rt_u = 1; s.exe_a = 3; s.mem_a = 3; s.mem_w = 1;
    add(s, ex(2, 2, C_NORMAL, 0, 0));
    foreach (stim_q[i]) begin
      apply(stim_q[i]); sb.push_back(want_q[i]);
      #2; e = sb.pop_front(); n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL fwd[%0d]: got fa=%0d fb=%0d ctl=%b sc=%0d fc=%0d, want fa=%0d fb=%0d ctl=%b sc=%0d fc=%0d",
                 i, got.fa, got.fb, got.ctl, got.sc, got.fc, e.fa, e.fb, e.ctl, e.sc, e.fc);
      end else $display("fwd[%0d] ok fa=%0d fb=%0d", i, got.fa, got.fb);
      @(posedge clk); #1;
    end
    stim_q.delete(); want_q.delete();
  endtask

  task automatic test_load_use();
    in_t s;
    obs_t e;
    do_reset();
    add(lu_exe(1'b0), ex(0, 0, C_STALL, 0, 0));
    add(lu_mem(1'b0), ex(3, 0, C_STALL, 1, 0));
    s = idle(); s.rs = 5; s.rs_u = 1;
    add(s, ex(0, 0, C_NORMAL, 2, 0));
    add(idle(), ex(0, 0, C_NORMAL, 2, 0));
    foreach (stim_q[i]) begin
      apply(stim_q[i]); sb.push_back(want_q[i]);
      #2; e = sb.pop_front(); n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL load_use[%0d]: got fa=%0d fb=%0d ctl=%b sc=%0d fc=%0d, want fa=%0d fb=%0d ctl=%b sc=%0d fc=%0d",
                 i, got.fa, got.fb, got.ctl, got.sc, got.fc, e.fa, e.fb, e.ctl, e.sc, e.fc);
      end else $display("load_use[%0d] ok ctl=%b sc=%0d", i, got.ctl, got.sc);
      @(posedge clk); #1;
    end
    stim_q.delete(); want_q.delete();
  endtask

  task automatic test_mem_wait();
    in_t s;
    obs_t e;
    do_reset();
    add(lu_exe(1'b0), ex(0, 0, C_STALL, 0, 0));
    s = lu_mem(1'b0); s.dreq = 1'b1;
    for (int k = 0; k < 3; k++) add(s, ex(3, 0, C_FREEZE, 1, 0));
    s.dack = 1'b1;
    add(s, ex(3, 0, C_STALL, 1, 0));
    add(idle(), ex(0, 0, C_NORMAL, 2, 0));
    foreach (stim_q[i]) begin
      apply(stim_q[i]); sb.push_back(want_q[i]);
      #2; e = sb.pop_front(); n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL mem_wait[%0d]: got fa=%0d fb=%0d ctl=%b sc=%0d fc=%0d, want fa=%0d fb=%0d ctl=%b sc=%0d fc=%0d",
                 i, got.fa, got.fb, got.ctl, got.sc, got.fc, e.fa, e.fb, e.ctl, e.sc, e.fc);
      end else $display("mem_wait[%0d] ok ctl=%b sc=%0d", i, got.ctl, got.sc);
      @(posedge clk); #1;
    end
    stim_q.delete(); want_q.delete();
  endtask

  task automatic test_branch();
    in_t s;
    obs_t e;
    do_reset();
    s = idle(); s.br = 1'b1;
    add(s, ex(0, 0, C_FLUSH, 0, 0));
    add(idle(), ex(0, 0, C_NORMAL, 0, 1));
    s = lu_exe(1'b0); s.br = 1'b1;
    add(s, ex(0, 0, C_STALL, 0, 1));
    s = lu_mem(1'b0); s.br = 1'b1;
    add(s, ex(3, 0, C_STALL, 1, 1));
    s = idle(); s.br = 1'b1;
    add(s, ex(0, 0, C_FLUSH, 2, 1));
    add(idle(), ex(0, 0, C_NORMAL, 2, 2));
    s = idle(); s.br = 1'b1; s.dreq = 1'b1;
    add(s, ex(0, 0, C_FREEZE, 2, 2));
    add(idle(), ex(0, 0, C_NORMAL, 2, 2));
    foreach (stim_q[i]) begin
      apply(stim_q[i]); sb.push_back(want_q[i]);
      #2; e = sb.pop_front(); n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL branch[%0d]: got fa=%0d fb=%0d ctl=%b sc=%0d fc=%0d, want fa=%0d fb=%0d ctl=%b sc=%0d fc=%0d",
                 i, got.fa, got.fb, got.ctl, got.sc, got.fc, e.fa, e.fb, e.ctl, e.sc, e.fc);
      end else $display("branch[%0d] ok ctl=%b fc=%0d", i, got.ctl, got.fc);
      @(posedge clk); #1;
    end
    stim_q.delete(); want_q.delete();
  endtask

  task automatic test_debug_step();
    in_t s;
    obs_t e;
    do_reset();
    s = idle(); s.den = 1'b1;
    add(s, ex(0, 0, C_FREEZE, 0, 0));
    s.dstep = 1'b1; s.br = 1'b1;
    add(s, ex(0, 0, C_FLUSH, 0, 0));
    for (int k = 0; k < 4; k++) add(s, ex(0, 0, C_FREEZE, 0, 1));
    s.dstep = 1'b0;
    add(s, ex(0, 0, C_FREEZE, 0, 1));
    s.dstep = 1'b1;
    add(s, ex(0, 0, C_FLUSH, 0, 1));
    add(idle(), ex(0, 0, C_NORMAL, 0, 2));
    foreach (stim_q[i]) begin
      apply(stim_q[i]); sb.push_back(want_q[i]);
      #2; e = sb.pop_front(); n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL debug[%0d]: got fa=%0d fb=%0d ctl=%b sc=%0d fc=%0d, want fa=%0d fb=%0d ctl=%b sc=%0d fc=%0d",
                 i, got.fa, got.fb, got.ctl, got.sc, got.fc, e.fa, e.fb, e.ctl, e.sc, e.fc);
      end else $display("debug[%0d] ok ctl=%b fc=%0d", i, got.ctl, got.fc);
      @(posedge clk); #1;
    end
    stim_q.delete(); want_q.delete();
  endtask

  task automatic test_saturation();
    in_t s;
    obs_t e;
    do_reset();
    s = idle(); s.br = 1'b1;
    for (int k = 0; k < 5; k++) add(s, ex(0, 0, C_FLUSH, 0, (k > 3) ? 3 : k));
    add(idle(), ex(0, 0, C_NORMAL, 0, 3));
    add(lu_exe(1'b0), ex(0, 0, C_STALL, 0, 3));
    add(lu_mem(1'b0), ex(3, 0, C_STALL, 1, 3));
    add(lu_exe(1'b1), ex(0, 0, C_STALL, 2, 3));
    add(lu_mem(1'b1), ex(0, 3, C_STALL, 3, 3));
    add(idle(), ex(0, 0, C_NORMAL, 3, 3));
    foreach (stim_q[i]) begin
      apply(stim_q[i]); sb.push_back(want_q[i]);
      #2; e = sb.pop_front(); n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL saturate[%0d]: got fa=%0d fb=%0d ctl=%b sc=%0d fc=%0d, want fa=%0d fb=%0d ctl=%b sc=%0d fc=%0d",
                 i, got.fa, got.fb, got.ctl, got.sc, got.fc, e.fa, e.fb, e.ctl, e.sc, e.fc);
      end else $display("saturate[%0d] ok sc=%0d fc=%0d", i, got.sc, got.fc);
      @(posedge clk); #1;
    end
    stim_q.delete(); want_q.delete();
  endtask

  initial begin
    do_reset();
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_branch();
    test_debug_step();
    test_saturation();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
